// File: rtl/cordic_pkg.sv
// Shared definitions for the iterative CORDIC sine/cosine sequencer.
//   ANGLE_W / DATA_W : widths of the binary angle and of the Q2.30 data path
//   K_INIT           : CORDIC gain compensation, 0.6072529 in Q2.30
//   atan_lut()       : atan(2^-i) as a binary angle (2^32 = one turn), i = 0..29
//   state_e          : sequencer states
package cordic_pkg;

    localparam int ANGLE_W = 32;
    localparam int DATA_W  = 32;
    localparam int ATAN_N  = 30;

    localparam logic [DATA_W-1:0] K_INIT = 32'h26DD3B6A;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ITERATE,
        MAP,
        DONE
    } state_e;

    // Entries 30 and 31 are never addressed by a legal ITER; they read as zero.
    function automatic logic [ANGLE_W-1:0] atan_lut(input logic [4:0] idx);
        case (idx)
            5'd0:    return 32'h20000000;
            5'd1:    return 32'h12E4051E;
            5'd2:    return 32'h09FB385B;
            5'd3:    return 32'h051111D4;
            5'd4:    return 32'h028B0D43;
            5'd5:    return 32'h0145D7E1;
            5'd6:    return 32'h00A2F61E;
            5'd7:    return 32'h00517C55;
            5'd8:    return 32'h0028BE53;
            5'd9:    return 32'h00145F2F;
            5'd10:   return 32'h000A2F98;
            5'd11:   return 32'h000517CC;
            5'd12:   return 32'h00028BE6;
            5'd13:   return 32'h000145F3;
            5'd14:   return 32'h0000A2FA;
            5'd15:   return 32'h0000517D;
            5'd16:   return 32'h000028BE;
            5'd17:   return 32'h0000145F;
            5'd18:   return 32'h00000A30;
            5'd19:   return 32'h00000518;
            5'd20:   return 32'h0000028C;
            5'd21:   return 32'h00000146;
            5'd22:   return 32'h000000A3;
            5'd23:   return 32'h00000051;
            5'd24:   return 32'h00000029;
            5'd25:   return 32'h00000014;
            5'd26:   return 32'h0000000A;
            5'd27:   return 32'h00000005;
            5'd28:   return 32'h00000003;
            5'd29:   return 32'h00000001;
            default: return 32'h00000000;
        endcase
    endfunction

endpackage

// File: rtl/cordic_microrot.sv
// One combinational CORDIC micro-rotation (rotation mode).
//   x_i, y_i  : current vector, signed Q2.30
//   z_i       : residual angle, signed binary angle
//   shift_i   : iteration index i (shift amount)
//   atan_i    : atan(2^-i) as a binary angle
//   x_o,y_o,z_o : rotated vector and updated residual
// Build option CORDIC_ROUND_EN: when defined, the shifted terms are rounded
// half-up instead of truncated (index 0 is an exact shift either way).
module cordic_microrot
    import cordic_pkg::*;
(
    input  logic signed [DATA_W-1:0]  x_i,
    input  logic signed [DATA_W-1:0]  y_i,
    input  logic signed [ANGLE_W-1:0] z_i,
    input  logic        [4:0]         shift_i,
    input  logic        [ANGLE_W-1:0] atan_i,
    output logic signed [DATA_W-1:0]  x_o,
    output logic signed [DATA_W-1:0]  y_o,
    output logic signed [ANGLE_W-1:0] z_o
);

    function automatic logic signed [DATA_W-1:0] shr(
        input logic signed [DATA_W-1:0] v,
        input logic        [4:0]        sh
    );
`ifdef CORDIC_ROUND_EN
        logic signed [DATA_W-1:0] bias;
        if (sh == 5'd0) begin
            return v;
        end
        bias = DATA_W'(1) << (sh - 5'd1);
        return (v + bias) >>> sh;
`else
        return v >>> sh;
`endif
    endfunction

    logic signed [DATA_W-1:0] x_sh;
    logic signed [DATA_W-1:0] y_sh;

    // Both shifted terms come from the old x/y, so the update is simultaneous.
    assign x_sh = shr(x_i, shift_i);
    assign y_sh = shr(y_i, shift_i);

    always_comb begin
        if (!z_i[ANGLE_W-1]) begin
            x_o = x_i - y_sh;
            y_o = y_i + x_sh;
            z_o = z_i - $signed(atan_i);
        end else begin
            x_o = x_i + y_sh;
            y_o = y_i - x_sh;
            z_o = z_i + $signed(atan_i);
        end
    end

endmodule

// File: rtl/cordic_rr_sequencer.sv
// Iterative CORDIC sine/cosine engine shared by two requesters.
//   clk, reset               : clock, asynchronous active-high reset
//   reqN_valid/angle/ready   : angle request from requester N (binary angle,
//                              2^32 = one turn); ready only in IDLE for the
//                              round-robin winner
//   out_valid/out_ready      : result handshake; out_cos/out_sin are signed
//                              Q2.30, out_id names the owning requester
//   busy                     : high whenever a job is in flight
// Parameters: ITER micro-rotations (8..30); TOL_SHIFT is informational.
// Build option CORDIC_ROUND_EN selects rounded shifts in cordic_microrot.
module cordic_rr_sequencer
    import cordic_pkg::*;
#(
    parameter int ITER      = 24,
    parameter int TOL_SHIFT = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0_valid,
    input  logic [ANGLE_W-1:0] req0_angle,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [ANGLE_W-1:0] req1_angle,
    output logic               req1_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_cos,
    output logic [DATA_W-1:0]  out_sin,
    output logic               out_id,
    output logic               busy
);

    if (ITER < 8 || ITER > ATAN_N || TOL_SHIFT < 0) begin : g_bad_param
        $error("cordic_rr_sequencer: ITER must lie in 8..30");
    end

    localparam logic [4:0] LAST_IDX = 5'(ITER - 1);

    state_e                    state_q,   state_d;
    logic                      rr_ptr_q,  rr_ptr_d;
    logic [ANGLE_W-1:0]        angle_q,   angle_d;
    logic                      id_q,      id_d;
    logic [1:0]                quad_q,    quad_d;
    logic [4:0]                cnt_q,     cnt_d;
    logic signed [DATA_W-1:0]  x_q,       x_d;
    logic signed [DATA_W-1:0]  y_q,       y_d;
    logic signed [ANGLE_W-1:0] z_q,       z_d;
    logic [DATA_W-1:0]         out_cos_q, out_cos_d;
    logic [DATA_W-1:0]         out_sin_q, out_sin_d;
    logic                      out_id_q,  out_id_d;

    logic signed [DATA_W-1:0]  x_nx;
    logic signed [DATA_W-1:0]  y_nx;
    logic signed [ANGLE_W-1:0] z_nx;

    logic grant;
    logic grant_vld;

    // A lone requester wins outright; a tie goes to the round-robin pointer.
    assign grant_vld  = (state_q == IDLE) && (req0_valid || req1_valid);
    assign grant      = (req0_valid && req1_valid) ? rr_ptr_q : req1_valid;
    assign req0_ready = grant_vld && !grant;
    assign req1_ready = grant_vld &&  grant;

    cordic_microrot u_microrot (
        .x_i     (x_q),
        .y_i     (y_q),
        .z_i     (z_q),
        .shift_i (cnt_q),
        .atan_i  (atan_lut(cnt_q)),
        .x_o     (x_nx),
        .y_o     (y_nx),
        .z_o     (z_nx)
    );

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        angle_d   = angle_q;
        id_d      = id_q;
        quad_d    = quad_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        z_d       = z_q;
        out_cos_d = out_cos_q;
        out_sin_d = out_sin_q;
        out_id_d  = out_id_q;

        unique case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    angle_d  = grant ? req1_angle : req0_angle;
                    id_d     = grant;
                    rr_ptr_d = !grant;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                // The top two bits select the quadrant; the rest is a residual
                // in [0, 90 deg), well inside the CORDIC convergence range.
                quad_d  = angle_q[ANGLE_W-1 -: 2];
                z_d     = {2'b00, angle_q[ANGLE_W-3:0]};
                x_d     = K_INIT;
                y_d     = '0;
                cnt_d   = '0;
                state_d = ITERATE;
            end
            ITERATE: begin
                x_d = x_nx;
                y_d = y_nx;
                z_d = z_nx;
                if (cnt_q == LAST_IDX) begin
                    state_d = MAP;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            MAP: begin
                unique case (quad_q)
                    2'd0: begin out_cos_d =  x_q; out_sin_d =  y_q; end
                    2'd1: begin out_cos_d = -y_q; out_sin_d =  x_q; end
                    2'd2: begin out_cos_d = -x_q; out_sin_d = -y_q; end
                    default: begin out_cos_d = y_q; out_sin_d = -x_q; end
                endcase
                out_id_d = id_q;
                state_d  = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rr_ptr_q  <= 1'b0;
            angle_q   <= '0;
            id_q      <= 1'b0;
            quad_q    <= '0;
            cnt_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            out_cos_q <= '0;
            out_sin_q <= '0;
            out_id_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            angle_q   <= angle_d;
            id_q      <= id_d;
            quad_q    <= quad_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            z_q       <= z_d;
            out_cos_q <= out_cos_d;
            out_sin_q <= out_sin_d;
            out_id_q  <= out_id_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_cos   = out_cos_q;
    assign out_sin   = out_sin_q;
    assign out_id    = out_id_q;

endmodule

// File: tb/tb_cordic_rr_sequencer.sv
// Self-checking bench for cordic_rr_sequencer: table of angles with expected
// Q2.30 results, a scoreboard of accepted jobs checked at the output
// handshake, and directed sequences for latency, arbitration, backpressure
// and mid-job reset.
module tb_cordic_rr_sequencer;

    // 30 iterations keep the residual-angle error far below the 64 LSB bound.
    localparam int TB_ITER = 30;
    localparam int TOL     = 64;

    logic        clk;
    logic        reset;
    logic        req0_valid;
    logic [31:0] req0_angle;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_angle;
    logic        req1_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_cos;
    logic [31:0] out_sin;
    logic        out_id;
    logic        busy;

    cordic_rr_sequencer #(.ITER(TB_ITER), .TOL_SHIFT(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_angle (req0_angle),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_angle (req1_angle),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_cos    (out_cos),
        .out_sin    (out_sin),
        .out_id     (out_id),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit                 id;
        logic        [31:0] angle;
        logic signed [31:0] ecos;
        logic signed [31:0] esin;
    } vec_t;

    vec_t tbl [12];
    vec_t sb [$];
    bit   seen_ids [$];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_near(input string name, input logic signed [31:0] act,
                              input logic signed [31:0] exp);
        longint d;
        d = longint'(act) - longint'(exp);
        if (d < 0) d = -d;
        n_cmp++;
        if (d > TOL) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (+/-%0d)", name, act, exp, TOL);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    // Reference from real arithmetic, independent of the CORDIC algorithm.
    function automatic logic signed [31:0] model(input logic [31:0] a, input bit want_sin);
        longint al;
        real    th;
        real    v;
        al = longint'(a);
        th = real'(al) * 6.283185307179586 / 4294967296.0;
        v  = (want_sin ? $sin(th) : $cos(th)) * 1073741824.0;
        return $rtoi(v);
    endfunction

    // Output side of the scoreboard.
    initial begin
        vec_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_output: got id %0d cos %h sin %h, expected none",
                             out_id, out_cos, out_sin);
                end else begin
                    e = sb.pop_front();
                    check("out_id", 64'(out_id), 64'(e.id));
                    check_near("out_cos", out_cos, e.ecos);
                    check_near("out_sin", out_sin, e.esin);
                    seen_ids.push_back(out_id);
                end
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send(input bit id, input logic [31:0] ang,
                        input logic signed [31:0] ec, input logic signed [31:0] es);
        bit done = 1'b0;
        if (id) begin req1_valid = 1'b1; req1_angle = ang; end
        else    begin req0_valid = 1'b1; req0_angle = ang; end
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) begin
                sb.push_back('{id, ang, ec, es});
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        // Scramble the angle so a design that fails to latch it is caught.
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_angle = ~ang; req1_angle = ~ang;
        if (!done) timeout_fail("send_handshake");
    endtask

    task automatic send_pair(input logic [31:0] a0, input logic [31:0] a1);
        bit d0 = 1'b0;
        bit d1 = 1'b0;
        req0_valid = 1'b1; req0_angle = a0;
        req1_valid = 1'b1; req1_angle = a1;
        for (int k = 0; k < 400 && !(d0 && d1); k++) begin
            @(negedge clk);
            if (req0_valid && req0_ready) begin
                sb.push_back('{1'b0, a0, model(a0, 1'b0), model(a0, 1'b1)});
                d0 = 1'b1;
            end
            if (req1_valid && req1_ready) begin
                sb.push_back('{1'b1, a1, model(a1, 1'b0), model(a1, 1'b1)});
                d1 = 1'b1;
            end
            @(posedge clk); #1;
            if (d0) req0_valid = 1'b0;
            if (d1) req1_valid = 1'b0;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        if (!(d0 && d1)) timeout_fail("pair_handshake");
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while ((sb.size() != 0 || busy) && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 300) timeout_fail(name);
    endtask

    task automatic check_order(input string name, input bit first, input bit second);
        check({name, "_count"}, 64'(seen_ids.size()), 64'd2);
        if (seen_ids.size() == 2) begin
            check({name, "_first"},  64'(seen_ids[0]), 64'(first));
            check({name, "_second"}, 64'(seen_ids[1]), 64'(second));
        end
    endtask

    initial begin
        int          n;
        logic [31:0] hold_cos;
        logic [31:0] hold_sin;

        tbl[0]  = '{1'b0, 32'h00000000, 32'h40000000, 32'h00000000};
        tbl[1]  = '{1'b1, 32'h40000000, 32'h00000000, 32'h40000000};
        tbl[2]  = '{1'b0, 32'h20000000, 32'h2D413CCD, 32'h2D413CCD};
        tbl[3]  = '{1'b1, 32'hC0000000, 32'h00000000, 32'hC0000000};
        tbl[4]  = '{1'b0, 32'h80000000, 32'hC0000000, 32'h00000000};
        tbl[5]  = '{1'b1, 32'h15555555, 32'h376CF5D1, 32'h20000000};
        tbl[6]  = '{1'b0, 32'h2AAAAAAB, 32'h20000000, 32'h376CF5D1};
        tbl[7]  = '{1'b1, 32'h95555555, 32'hC8930A2F, 32'hE0000000};
        tbl[8]  = '{1'b0, 32'hD5555555, 32'h20000000, 32'hC8930A2F};
        tbl[9]  = '{1'b1, 32'hFFFFFFFF, 32'h40000000, 32'h00000000};
        tbl[10] = '{1'b0, 32'h3FFFFFFF, 32'h00000000, 32'h40000000};
        tbl[11] = '{1'b1, 32'h60000000, 32'hD2BEC333, 32'h2D413CCD};

        reset      = 1'b1;
        req0_valid = 1'b0; req0_angle = '0;
        req1_valid = 1'b0; req1_angle = '0;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_out_cos",   64'(out_cos),   64'd0);
        check("rst_out_sin",   64'(out_sin),   64'd0);
        check("rst_out_id",    64'(out_id),    64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // First-result latency, counted in rising edges after the handshake.
        send(1'b0, 32'h00000000, 32'h40000000, 32'h00000000);
        check("load_busy", 64'(busy), 64'd1);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", 64'(n), 64'(TB_ITER + 2));
        wait_drain("drain_latency");

        for (int i = 0; i < 12; i++) begin
            send(tbl[i].id, tbl[i].angle, tbl[i].ecos, tbl[i].esin);
            wait_drain("drain_table");
        end

        // Simultaneous requests straight out of reset: pointer starts at 0.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        seen_ids.delete();
        send_pair(32'h10000000, 32'h30000000);
        wait_drain("drain_pair_a");
        check_order("pair_from_reset", 1'b0, 1'b1);

        // A lone req0 job leaves the pointer at 1, so the tie goes to req1.
        send(1'b0, 32'h08000000, model(32'h08000000, 1'b0), model(32'h08000000, 1'b1));
        wait_drain("drain_single");
        seen_ids.delete();
        send_pair(32'h10000000, 32'h30000000);
        wait_drain("drain_pair_b");
        check_order("pair_repeat", 1'b1, 1'b0);

        // Backpressure in DONE.
        out_ready = 1'b0;
        seen_ids.delete();
        send(1'b1, 32'h0C000000, model(32'h0C000000, 1'b0), model(32'h0C000000, 1'b1));
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) timeout_fail("bp_wait_valid");
        hold_cos = out_cos;
        hold_sin = out_sin;
        req0_valid = 1'b1; req0_angle = 32'h11111111;
        req1_valid = 1'b1; req1_angle = 32'h22222222;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("bp_hold", {28'd0, out_valid, out_id, req0_ready, req1_ready, out_cos, out_sin},
                  {28'd0, 1'b1, 1'b1, 1'b0, 1'b0, hold_cos, hold_sin});
        end
        out_ready  = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk); #1;
        check("bp_idle_busy",  64'(busy),      64'd0);
        check("bp_idle_valid", 64'(out_valid), 64'd0);
        check("bp_handshakes", 64'(seen_ids.size()), 64'd1);
        wait_drain("drain_bp");

        // Reset in the fifth ITERATE cycle drops the job.
        send(1'b0, 32'h12345678, model(32'h12345678, 1'b0), model(32'h12345678, 1'b1));
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("mid_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy",      64'(busy),      64'd0);
        check("mid_rst_out_cos",   64'(out_cos),   64'd0);
        check("mid_rst_out_sin",   64'(out_sin),   64'd0);
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_valid", 64'(out_valid), 64'd0);
        seen_ids.delete();
        send_pair(32'h2468ACE0, 32'hB0000000);
        wait_drain("drain_post_rst");
        check_order("post_rst_pair", 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
